// File: rtl/vreg_write_arbiter.sv
// vreg_write_arbiter
//   Shares the single vector register file write port between the PE datapath
//   writeback (requester 0) and the vector load unit (requester 1). Packets are
//   arbitrated round-robin. A multi-beat packet keeps the port until its last
//   beat, or until the watchdog aborts it after LOCK_MAX_BEATS beats. Each
//   accepted beat is registered once and appears on rf_wr_* one cycle later.
// Ports
//   clk, n_reset           clock (rising edge), async active-low reset
//   pe_wr_*                PE beat channel (valid/ready/addr/data/be/last)
//   ld_wr_*                load unit beat channel (same fields)
//   rf_wr_en/addr/data/be  registered register-file write port
//   busy                   a packet is locked or a write is in the output stage
//   lock_err               sticky watchdog abort flag
module vreg_write_arbiter #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BE_W           = 4,
  parameter int unsigned LOCK_MAX_BEATS = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              pe_wr_valid,
  output logic              pe_wr_ready,
  input  logic [4:0]        pe_wr_addr,
  input  logic [DATA_W-1:0] pe_wr_data,
  input  logic [BE_W-1:0]   pe_wr_be,
  input  logic              pe_wr_last,
  input  logic              ld_wr_valid,
  output logic              ld_wr_ready,
  input  logic [4:0]        ld_wr_addr,
  input  logic [DATA_W-1:0] ld_wr_data,
  input  logic [BE_W-1:0]   ld_wr_be,
  input  logic              ld_wr_last,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [BE_W-1:0]   rf_wr_be,
  output logic              busy,
  output logic              lock_err
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOCK_PE, LOCK_LD} state_t;
  typedef enum logic {RR_PE, RR_LD} rr_t;

  state_t            r_state;
  rr_t               r_rr_ptr;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_wr_en;
  logic [4:0]        r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [BE_W-1:0]   r_wr_be;
  logic              r_lock_err;

  logic              w_pe_ready;
  logic              w_ld_ready;
  logic              w_pe_xfer;
  logic              w_ld_xfer;
  logic              w_xfer;
  logic              w_last;
  logic              w_abort;
  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic [BE_W-1:0]   w_be;
  logic [CNT_W-1:0]  w_beat_num;

  // Grants depend only on state, valids and rr_ptr; gated off during reset.
  always_comb begin
    w_pe_ready = 1'b0;
    w_ld_ready = 1'b0;
    if (n_reset) begin
      case (r_state)
        IDLE: begin
          w_pe_ready = pe_wr_valid && (!ld_wr_valid || r_rr_ptr == RR_PE);
          w_ld_ready = ld_wr_valid && (!pe_wr_valid || r_rr_ptr == RR_LD);
        end
        LOCK_PE: w_pe_ready = 1'b1;
        LOCK_LD: w_ld_ready = 1'b1;
        default: begin
          w_pe_ready = 1'b0;
          w_ld_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_pe_xfer  = pe_wr_valid && w_pe_ready;
    w_ld_xfer  = ld_wr_valid && w_ld_ready;
    w_xfer     = w_pe_xfer || w_ld_xfer;
    w_last     = w_ld_xfer ? ld_wr_last : pe_wr_last;
    w_addr     = w_ld_xfer ? ld_wr_addr : pe_wr_addr;
    w_data     = w_ld_xfer ? ld_wr_data : pe_wr_data;
    w_be       = w_ld_xfer ? ld_wr_be   : pe_wr_be;
    // Ordinal of the beat being accepted within its packet.
    w_beat_num = r_beat_cnt + CNT_W'(1);
    w_abort    = w_xfer && !w_last && (w_beat_num >= CNT_W'(LOCK_MAX_BEATS));
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= RR_PE;
      r_beat_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_be    <= '0;
      r_lock_err <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_xfer) begin
        // Beat is always consumed; a zero byte-enable beat just does not write.
        r_wr_en   <= |w_be;
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_wr_be   <= w_be;
        if (w_last || w_abort) begin
          // Completion or watchdog abort: release the port and favour the other side.
          r_state    <= IDLE;
          r_beat_cnt <= '0;
          r_rr_ptr   <= w_ld_xfer ? RR_PE : RR_LD;
          if (w_abort) r_lock_err <= 1'b1;
        end else begin
          r_state    <= w_ld_xfer ? LOCK_LD : LOCK_PE;
          r_beat_cnt <= w_beat_num;
        end
      end
    end
  end

  assign pe_wr_ready = w_pe_ready;
  assign ld_wr_ready = w_ld_ready;
  assign rf_wr_en    = r_wr_en;
  assign rf_wr_addr  = r_wr_addr;
  assign rf_wr_data  = r_wr_data;
  assign rf_wr_be    = r_wr_be;
  assign lock_err    = r_lock_err;
  assign busy        = (r_state != IDLE) || r_wr_en;

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Directed bench for vreg_write_arbiter: round-robin, packet locking,
// zero byte-enable beats, watchdog abort and asynchronous reset mid-packet.
module tb_vreg_write_arbiter;

  logic        clk;
  logic        n_reset;
  logic        pe_wr_valid, pe_wr_ready, pe_wr_last;
  logic [4:0]  pe_wr_addr;
  logic [31:0] pe_wr_data;
  logic [3:0]  pe_wr_be;
  logic        ld_wr_valid, ld_wr_ready, ld_wr_last;
  logic [4:0]  ld_wr_addr;
  logic [31:0] ld_wr_data;
  logic [3:0]  ld_wr_be;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [3:0]  rf_wr_be;
  logic        busy, lock_err;

  int n_assert = 0;
  int n_fail   = 0;

  vreg_write_arbiter #(.DATA_W(32), .BE_W(4), .LOCK_MAX_BEATS(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .pe_wr_valid(pe_wr_valid), .pe_wr_ready(pe_wr_ready), .pe_wr_addr(pe_wr_addr),
    .pe_wr_data(pe_wr_data), .pe_wr_be(pe_wr_be), .pe_wr_last(pe_wr_last),
    .ld_wr_valid(ld_wr_valid), .ld_wr_ready(ld_wr_ready), .ld_wr_addr(ld_wr_addr),
    .ld_wr_data(ld_wr_data), .ld_wr_be(ld_wr_be), .ld_wr_last(ld_wr_last),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_be(rf_wr_be), .busy(busy), .lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pe_drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic last);
    pe_wr_valid = v; pe_wr_addr = a; pe_wr_data = d; pe_wr_be = be; pe_wr_last = last;
  endtask

  task automatic ld_drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic last);
    ld_wr_valid = v; ld_wr_addr = a; ld_wr_data = d; ld_wr_be = be; ld_wr_last = last;
  endtask

  initial begin
    n_reset = 1'b0;
    pe_drive(1'b1, 5'd0, 32'h0, 4'hF, 1'b1);
    ld_drive(1'b1, 5'd0, 32'h0, 4'hF, 1'b1);
    #1;
    // Reset state: readies blocked even with both valid
    chk("rst_pe_ready", pe_wr_ready, 1'b0);
    chk("rst_ld_ready", ld_wr_ready, 1'b0);
    chk("rst_rf_en", rf_wr_en, 1'b0);
    chk("rst_rf_addr", rf_wr_addr, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lock_err", lock_err, 1'b0);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    ld_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick(); tick();
    n_reset = 1'b1;
    tick();

    // PE-only 3-beat packet to v4..v6
    pe_drive(1'b1, 5'd4, 32'hA000_0004, 4'hF, 1'b0);
    #1;
    chk("t1_pe_ready_b1", pe_wr_ready, 1'b1);
    chk("t1_ld_ready_b1", ld_wr_ready, 1'b0);
    chk("t1_en_before", rf_wr_en, 1'b0);
    tick();
    chk("t1_en_b1", rf_wr_en, 1'b1);
    chk("t1_addr_b1", rf_wr_addr, 5'd4);
    chk("t1_data_b1", rf_wr_data, 32'hA000_0004);
    chk("t1_busy_b1", busy, 1'b1);
    pe_drive(1'b1, 5'd5, 32'hA000_0005, 4'hF, 1'b0);
    tick();
    chk("t1_en_b2", rf_wr_en, 1'b1);
    chk("t1_addr_b2", rf_wr_addr, 5'd5);
    pe_drive(1'b1, 5'd6, 32'hA000_0006, 4'hF, 1'b1);
    tick();
    chk("t1_en_b3", rf_wr_en, 1'b1);
    chk("t1_addr_b3", rf_wr_addr, 5'd6);
    chk("t1_be_b3", rf_wr_be, 4'hF);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick();
    chk("t1_en_idle", rf_wr_en, 1'b0);
    chk("t1_addr_hold", rf_wr_addr, 5'd6);
    chk("t1_data_hold", rf_wr_data, 32'hA000_0006);
    chk("t1_busy_idle", busy, 1'b0);

    // Both valid from reset, single-beat packets
    n_reset = 1'b0;
    #2;
    n_reset = 1'b1;
    pe_drive(1'b1, 5'd1, 32'hB000_0001, 4'hF, 1'b1);
    ld_drive(1'b1, 5'd2, 32'hC000_0002, 4'h3, 1'b1);
    #1;
    chk("t2_pe_ready_c1", pe_wr_ready, 1'b1);
    chk("t2_ld_ready_c1", ld_wr_ready, 1'b0);
    tick();
    chk("t2_addr_c1", rf_wr_addr, 5'd1);
    chk("t2_en_c1", rf_wr_en, 1'b1);
    pe_drive(1'b1, 5'd3, 32'hB000_0003, 4'hF, 1'b1);
    #1;
    chk("t2_pe_ready_c2", pe_wr_ready, 1'b0);
    chk("t2_ld_ready_c2", ld_wr_ready, 1'b1);
    tick();
    chk("t2_addr_c2", rf_wr_addr, 5'd2);
    chk("t2_data_c2", rf_wr_data, 32'hC000_0002);
    chk("t2_be_c2", rf_wr_be, 4'h3);
    chk("t2_pe_ready_back", pe_wr_ready, 1'b1);
    chk("t2_ld_ready_back", ld_wr_ready, 1'b0);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    ld_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick();
    chk("t2_en_idle", rf_wr_en, 1'b0);

    // LD 4-beat packet; PE raises valid on beat 2 and must wait
    ld_drive(1'b1, 5'd8, 32'hD000_0008, 4'hF, 1'b0);
    #1;
    chk("t3_ld_ready_b1", ld_wr_ready, 1'b1);
    tick();
    ld_drive(1'b1, 5'd9, 32'hD000_0009, 4'hF, 1'b0);
    pe_drive(1'b1, 5'd20, 32'hB000_0014, 4'hF, 1'b1);
    #1;
    chk("t3_pe_ready_b2", pe_wr_ready, 1'b0);
    chk("t3_ld_ready_b2", ld_wr_ready, 1'b1);
    tick();
    chk("t3_addr_b2", rf_wr_addr, 5'd9);
    ld_drive(1'b1, 5'd10, 32'hD000_000A, 4'hF, 1'b0);
    #1;
    chk("t3_pe_ready_b3", pe_wr_ready, 1'b0);
    tick();
    ld_drive(1'b1, 5'd11, 32'hD000_000B, 4'hF, 1'b1);
    #1;
    chk("t3_pe_ready_b4", pe_wr_ready, 1'b0);
    tick();
    chk("t3_addr_b4", rf_wr_addr, 5'd11);
    ld_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    #1;
    chk("t3_pe_ready_after", pe_wr_ready, 1'b1);
    tick();
    chk("t3_pe_addr", rf_wr_addr, 5'd20);
    chk("t3_pe_en", rf_wr_en, 1'b1);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick();

    // PE beat with be=0: consumed but not written
    pe_drive(1'b1, 5'd7, 32'hB000_0007, 4'h0, 1'b1);
    #1;
    chk("t4_pe_ready", pe_wr_ready, 1'b1);
    tick();
    chk("t4_en", rf_wr_en, 1'b0);
    chk("t4_busy", busy, 1'b0);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick();

    // Watchdog: LD never sends last; abort on beat 8
    for (int i = 0; i < 7; i++) begin
      ld_drive(1'b1, 5'(12 + i), 32'hE000_0000 + 32'(i), 4'hF, 1'b0);
      tick();
    end
    chk("t5_addr_b7", rf_wr_addr, 5'd18);
    chk("t5_lock_err_b7", lock_err, 1'b0);
    ld_drive(1'b1, 5'd19, 32'hE000_0007, 4'hF, 1'b0);
    pe_drive(1'b1, 5'd30, 32'hB000_001E, 4'hF, 1'b1);
    #1;
    chk("t5_pe_ready_locked", pe_wr_ready, 1'b0);
    chk("t5_ld_ready_b8", ld_wr_ready, 1'b1);
    tick();
    chk("t5_lock_err", lock_err, 1'b1);
    chk("t5_addr_b8", rf_wr_addr, 5'd19);
    chk("t5_en_b8", rf_wr_en, 1'b1);
    ld_drive(1'b1, 5'd20, 32'hE000_0008, 4'hF, 1'b0);
    #1;
    chk("t5_pe_ready_abort", pe_wr_ready, 1'b1);
    chk("t5_ld_ready_abort", ld_wr_ready, 1'b0);
    tick();
    chk("t5_pe_addr", rf_wr_addr, 5'd30);
    chk("t5_lock_err_sticky", lock_err, 1'b1);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    ld_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick();

    // Reset during LOCK_PE beat 2
    pe_drive(1'b1, 5'd16, 32'hB000_0010, 4'hF, 1'b0);
    tick();
    pe_drive(1'b1, 5'd17, 32'hB000_0011, 4'hF, 1'b0);
    tick();
    chk("t6_addr_b2", rf_wr_addr, 5'd17);
    #2;
    n_reset = 1'b0;
    #1;
    chk("t6_en", rf_wr_en, 1'b0);
    chk("t6_addr", rf_wr_addr, 5'd0);
    chk("t6_pe_ready", pe_wr_ready, 1'b0);
    chk("t6_ld_ready", ld_wr_ready, 1'b0);
    chk("t6_lock_err", lock_err, 1'b0);
    chk("t6_busy", busy, 1'b0);
    #1;
    n_reset = 1'b1;
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    ld_drive(1'b1, 5'd21, 32'hD000_0015, 4'hF, 1'b1);
    #1;
    chk("t6_idle_ld_ready", ld_wr_ready, 1'b1);
    pe_drive(1'b1, 5'd22, 32'hB000_0016, 4'hF, 1'b1);
    #1;
    chk("t6_rr_pe_ready", pe_wr_ready, 1'b1);
    chk("t6_rr_ld_ready", ld_wr_ready, 1'b0);
    pe_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    ld_drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
